// File: rtl/axi_console_pkg.sv
// axi_console_pkg: state encodings and constants shared by the console responder.
package axi_console_pkg;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} u_state_t;
    localparam logic [63:0] PASS_WORD  = 64'h444333222;
    localparam logic [63:0] FAIL_WORD  = 64'h2382348720;
    localparam logic [1:0]  BRESP_OKAY = 2'b00;
endpackage

// File: rtl/console_fifo.sv
// console_fifo: 8-bit synchronous character FIFO; extra pointer bit separates full from empty.
module console_fifo #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_b,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(FIFO_DEPTH);
    logic [AW:0] wr_ptr, rd_ptr;
    logic [7:0]  mem [FIFO_DEPTH];
    logic        do_push, do_pop;
    assign empty   = wr_ptr == rd_ptr;
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout    = mem[rd_ptr[AW-1:0]];
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/axi_console_tx.sv
// axi_console_tx: AXI write responder that forwards console bytes to an 8N1 UART.
// Finish-word pass/fail detection is built only when AXI_CONSOLE_FINISH_EN is defined.
module axi_console_tx
    import axi_console_pkg::*;
#(
    parameter logic [31:0] CONSOLE_ADDR = 32'h01ff_fff0,
    parameter logic [31:0] FINISH_ADDR  = 32'h01ff_ffe0,
    parameter int          FIFO_DEPTH   = 16,
    parameter int          CLK_DIV      = 868
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         awvalid,
    output logic         awready,
    input  logic [31:0]  awaddr,
    input  logic [3:0]   awlen,
    input  logic [7:0]   awid,
    input  logic         wvalid,
    output logic         wready,
    input  logic [127:0] wdata,
    input  logic [15:0]  wstrb,
    input  logic         wlast,
    output logic         bvalid,
    input  logic         bready,
    output logic [7:0]   bid,
    output logic [1:0]   bresp,
    output logic         uart_txd,
    output logic         tx_busy,
    output logic         test_pass,
    output logic         test_fail
);
    localparam int CW = $clog2(CLK_DIV);
    w_state_t    w_state;
    u_state_t    u_state;
    logic [27:0] base_addr, beat_addr;
    logic [3:0]  beat, len;
    logic        w_hs, strb_ok, push, pop, full, empty, tick, unused_ok;
    logic [7:0]  push_byte, dout, sh;
    logic [CW-1:0] cnt;
    logic [2:0]  bitn;
    assign beat_addr = base_addr + 28'(beat);
    assign wready    = (w_state == W_DATA) && !full;
    assign w_hs      = wvalid && wready;
    assign bresp     = BRESP_OKAY;
    assign strb_ok   = wstrb inside {16'h000f, 16'h00f0, 16'h0f00, 16'hf000};
    assign push_byte = wstrb == 16'h000f ? wdata[7:0] :
                       wstrb == 16'h00f0 ? wdata[39:32] :
                       wstrb == 16'h0f00 ? wdata[71:64] : wdata[103:96];
    assign push      = w_hs && strb_ok && beat_addr == CONSOLE_ADDR[31:4];
    assign unused_ok = ^{awaddr[3:0], len, wdata, FINISH_ADDR};
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            w_state   <= W_IDLE;
            awready   <= 1'b0;
            bvalid    <= 1'b0;
            bid       <= '0;
            base_addr <= '0;
            beat      <= '0;
            len       <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    awready <= 1'b1;
                    if (awvalid && awready) begin
                        base_addr <= awaddr[31:4];
                        len       <= awlen;
                        bid       <= awid;
                        beat      <= '0;
                        awready   <= 1'b0;
                        w_state   <= W_DATA;
                    end
                end
                W_DATA: if (w_hs) begin
                    beat <= beat + 1'b1;
                    if (wlast) begin
                        bvalid  <= 1'b1;
                        w_state <= W_RESP;
                    end
                end
                W_RESP: if (bready) begin
                    bvalid  <= 1'b0;
                    awready <= 1'b1;
                    w_state <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end
`ifdef AXI_CONSOLE_FINISH_EN
    logic fin_hit;
    assign fin_hit = w_hs && wstrb[7:0] == 8'hff && beat_addr == FINISH_ADDR[31:4];
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            test_pass <= 1'b0;
            test_fail <= 1'b0;
        end else begin
            if (fin_hit && wdata[63:0] == PASS_WORD) test_pass <= 1'b1;
            if (fin_hit && wdata[63:0] == FAIL_WORD) test_fail <= 1'b1;
        end
    end
`else
    assign test_pass = 1'b0;
    assign test_fail = 1'b0;
`endif
    console_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk  (clk),
        .rst_b(rst_b),
        .push (push),
        .din  (push_byte),
        .pop  (pop),
        .dout (dout),
        .full (full),
        .empty(empty)
    );
    // A new byte is taken either from idle or at the end of a stop bit, so frames run back to back.
    assign tick    = cnt == CW'(CLK_DIV - 1);
    assign pop     = !empty && (u_state == U_IDLE || (u_state == U_STOP && tick));
    assign tx_busy = !empty || u_state != U_IDLE;
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            u_state  <= U_IDLE;
            cnt      <= '0;
            bitn     <= '0;
            sh       <= '0;
            uart_txd <= 1'b1;
        end else begin
            cnt <= (u_state == U_IDLE || tick) ? '0 : cnt + 1'b1;
            case (u_state)
                U_IDLE: if (pop) begin
                    sh       <= dout;
                    uart_txd <= 1'b0;
                    u_state  <= U_START;
                end
                U_START: if (tick) begin
                    uart_txd <= sh[0];
                    sh       <= sh >> 1;
                    bitn     <= '0;
                    u_state  <= U_DATA;
                end
                U_DATA: if (tick) begin
                    if (bitn == 3'd7) begin
                        uart_txd <= 1'b1;
                        u_state  <= U_STOP;
                    end else begin
                        uart_txd <= sh[0];
                        sh       <= sh >> 1;
                        bitn     <= bitn + 1'b1;
                    end
                end
                U_STOP: if (tick) begin
                    if (pop) begin
                        sh       <= dout;
                        uart_txd <= 1'b0;
                        u_state  <= U_START;
                    end else begin
                        u_state  <= U_IDLE;
                    end
                end
                default: u_state <= U_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_console_tx.sv
// tb_axi_console_tx: table-driven AXI writes with a byte scoreboard checked by a UART receiver.
module tb_axi_console_tx;
    localparam int CLK_DIV = 4;
    localparam logic [31:0] CON = 32'h01ff_fff0;
    localparam logic [31:0] FIN = 32'h01ff_ffe0;
`ifdef AXI_CONSOLE_FINISH_EN
    localparam logic EXP_FIN = 1'b1;
`else
    localparam logic EXP_FIN = 1'b0;
`endif
    logic clk = 1'b0, rst_b = 1'b0;
    logic awvalid = 0, awready, wvalid = 0, wready, wlast = 0, bvalid, bready = 0;
    logic [31:0] awaddr = '0;
    logic [3:0] awlen = '0;
    logic [7:0] awid = '0, bid;
    logic [127:0] wdata = '0;
    logic [15:0] wstrb = '0;
    logic [1:0] bresp;
    logic uart_txd, tx_busy, test_pass, test_fail;
    axi_console_tx #(.FIFO_DEPTH(16), .CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst_b(rst_b),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen), .awid(awid),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
        .uart_txd(uart_txd), .tx_busy(tx_busy), .test_pass(test_pass), .test_fail(test_fail)
    );
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    int errs = 0, checks = 0;
    logic [7:0] exp_q[$];
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic timeout(input string name);
        checks++;
        errs++;
        $display("FAIL %s: got timeout expected handshake", name);
    endtask
    // UART receiver: samples mid-bit and pops the scoreboard once per frame
    int frames = 0, last_start = 0, prev_start = 0, rst_evt = 0, ev;
    bit prev_valid = 0, b2b_en = 0, mon_busy = 0;
    logic [7:0] rx;
    logic st0, stp;
    initial begin
        forever begin
            @(negedge clk);
            if (rst_b && uart_txd === 1'b0) begin
                mon_busy = 1;
                ev = rst_evt;
                last_start = cyc;
                if (b2b_en && prev_valid) chk("frame_gap", 128'(cyc - prev_start), 10 * CLK_DIV);
                prev_start = cyc;
                prev_valid = 1;
                repeat (CLK_DIV / 2) @(negedge clk);
                st0 = uart_txd;
                for (int i = 0; i < 8; i++) begin
                    repeat (CLK_DIV) @(negedge clk);
                    rx[i] = uart_txd;
                end
                repeat (CLK_DIV) @(negedge clk);
                stp = uart_txd;
                if (rst_evt == ev) begin
                    chk("start_bit", st0, 0);
                    chk("stop_bit", stp, 1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errs++;
                        $display("FAIL unexpected_byte: got %02h expected none", rx);
                    end else chk("rx_byte", rx, exp_q.pop_front());
                    frames++;
                end
                mon_busy = 0;
            end
        end
    end
    logic [127:0] bd[16];
    logic [15:0] bs[16];
    int hs_cyc;
    logic pass_hs, fail_hs;
    bit stalled;
    // Entered and left at a negedge; one write costs three cycles when the DUT never stalls.
    task automatic axi_write(input logic [31:0] addr, input logic [7:0] id, input int n);
        int t;
        awvalid = 1; awaddr = addr; awlen = 4'(n - 1); awid = id;
        t = 0;
        while (!awready && t < 200) begin @(negedge clk); t++; end
        if (!awready) begin timeout("aw_handshake"); awvalid = 0; return; end
        @(negedge clk);
        awvalid = 0;
        chk("awready_busy", awready, 0);
        for (int i = 0; i < n; i++) begin
            wvalid = 1; wdata = bd[i]; wstrb = bs[i]; wlast = (i == n - 1);
            t = 0;
            while (!wready && t < 2000) begin stalled = 1; @(negedge clk); t++; end
            if (!wready) begin timeout("w_handshake"); wvalid = 0; wlast = 0; return; end
            @(negedge clk);
            hs_cyc = cyc; pass_hs = test_pass; fail_hs = test_fail;
        end
        wvalid = 0; wlast = 0;
        chk("bvalid_next", bvalid, 1);
        chk("bid", bid, id);
        chk("bresp", bresp, 0);
        bready = 1;
        @(negedge clk);
        bready = 0;
        chk("bvalid_clr", bvalid, 0);
    endtask
    task automatic wait_drain();
        int t = 0;
        while ((exp_q.size() != 0 || tx_busy || mon_busy) && t < 20000) begin @(negedge clk); t++; end
        chk("drained", 128'(exp_q.size()), 0);
        chk("tx_idle", tx_busy, 0);
    endtask
    typedef struct {
        logic [31:0] addr;
        logic [15:0] strb;
        logic [127:0] data;
        logic push;
        logic [7:0] ch;
    } vec_t;
    vec_t tv[9];
    initial begin
        tv[0] = '{CON, 16'h000f, 128'h0f0e0d0c_0b0a0908_07060504_03020141, 1'b1, 8'h41};
        tv[1] = '{CON, 16'h00f0, 128'h0f0e0d0c_0b0a0908_07060562_03020100, 1'b1, 8'h62};
        tv[2] = '{CON, 16'h0f00, 128'h0f0e0d0c_0b0a09c3_07060504_03020100, 1'b1, 8'hc3};
        tv[3] = '{CON, 16'hf000, 128'h0f0e0da5_0b0a0908_07060504_03020100, 1'b1, 8'ha5};
        tv[4] = '{CON, 16'h00ff, 128'h0f0e0d0c_0b0a0908_07060504_03020100, 1'b0, 8'h00};
        tv[5] = '{CON, 16'h0000, 128'h0f0e0d0c_0b0a0908_07060504_03020100, 1'b0, 8'h00};
        tv[6] = '{32'h01ff_fff8, 16'h000f, 128'h0f0e0d0c_0b0a0908_07060504_0302017e, 1'b1, 8'h7e};
        tv[7] = '{32'h01ff_ffc0, 16'h000f, 128'h0f0e0d0c_0b0a0908_07060504_03020155, 1'b0, 8'h00};
        tv[8] = '{FIN, 16'h00ff, 128'h0, 1'b0, 8'h00};
        tv[8].data[15:0] = 16'h1234;
        repeat (3) @(negedge clk);
        chk("rst_awready", awready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_bid", bid, 0);
        chk("rst_bresp", bresp, 0);
        chk("rst_txd", uart_txd, 1);
        chk("rst_busy", tx_busy, 0);
        chk("rst_pass", test_pass, 0);
        chk("rst_fail", test_fail, 0);
        rst_b = 1;
        @(negedge clk);
        chk("awready_rise", awready, 1);
        for (int i = 0; i < 9; i++) begin
            bd[0] = tv[i].data;
            bs[0] = tv[i].strb;
            if (tv[i].push) exp_q.push_back(tv[i].ch);
            axi_write(tv[i].addr, 8'(i + 16), 1);
            if (i == 0) begin
                @(negedge clk);
                chk("txd_fall_delay", 128'(last_start - hs_cyc), 1);
            end
            chk("no_pass", test_pass, 0);
        end
        wait_drain();
        // burst from 0x01ff_ffd0: only beat 2 lands on the console word
        bd[0] = 128'h00000011_00000000_00000000_00000000;
        bd[1] = 128'h00000022_00000000_00000000_00000000;
        bd[2] = 128'h0000005a_00000000_00000000_00000000;
        bd[3] = 128'h00000044_00000000_00000000_00000000;
        for (int i = 0; i < 4; i++) bs[i] = 16'hf000;
        exp_q.push_back(8'h5a);
        axi_write(32'h01ff_ffd0, 8'hb7, 4);
        wait_drain();
        b2b_en = 1; prev_valid = 0; stalled = 0;
        for (int i = 0; i < 20; i++) begin
            bd[0] = {120'h0, 8'(8'h30 + i)};
            bs[0] = 16'h000f;
            exp_q.push_back(8'(8'h30 + i));
            axi_write(CON, 8'(i), 1);
        end
        chk("wready_stall", stalled, 1);
        wait_drain();
        b2b_en = 0;
        bd[0] = {64'h0, 64'h444333222};
        bs[0] = 16'h00ff;
        axi_write(FIN, 8'h5e, 1);
        chk("pass_next", pass_hs, EXP_FIN);
        chk("fail_clear", fail_hs, 0);
        repeat (20) @(negedge clk);
        chk("pass_sticky", test_pass, EXP_FIN);
        bd[0] = {64'h0, 64'h2382348720};
        axi_write(FIN, 8'h5f, 1);
        chk("fail_next", fail_hs, EXP_FIN);
        chk("pass_kept", test_pass, EXP_FIN);
        for (int i = 0; i < 4; i++) begin
            bd[0] = {120'h0, 8'(8'h00 + 8'(i * 3))};
            bs[0] = 16'h000f;
            exp_q.push_back(8'(i * 3));
            axi_write(CON, 8'(8'h70 + i), 1);
        end
        repeat (6) @(negedge clk);
        chk("mid_frame_low", uart_txd, 0);
        #2;
        rst_b = 0;
        rst_evt++;
        #1;
        chk("rst_txd_now", uart_txd, 1);
        chk("rst_busy_now", tx_busy, 0);
        chk("rst_pass_now", test_pass, 0);
        chk("rst_fail_now", test_fail, 0);
        chk("rst_awready_now", awready, 0);
        exp_q.delete();
        @(negedge clk);
        rst_b = 1;
        ev = frames;
        repeat (100) @(negedge clk);
        chk("no_frames_after_rst", 128'(frames - ev), 0);
        chk("txd_idle_after_rst", uart_txd, 1);
        chk("busy_after_rst", tx_busy, 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/axi_console_tx.md
# axi_console_tx

AXI write-channel responder for the SoC console and test-finish window. It accepts 128-bit AXI write bursts from the CPU BIU and extracts the character byte from each beat addressed to the console word. It queues those bytes in a FIFO and serialises them on an 8N1 UART line. It also flags pass/fail when the finish word is written, which makes it the synthesizable counterpart of the bench-side console snooper, usable on FPGA builds.

## Interface
- CONSOLE_ADDR, 32'h01ff_fff0, console beat address; compared on [31:4]
- FINISH_ADDR, 32'h01ff_ffe0, test-finish beat address; compared on [31:4]
- FIFO_DEPTH, 16, character FIFO entries; power of two, ≥2
- CLK_DIV, 868, clk cycles per UART bit; ≥2
- clk  in  1  single clock
- rst_b  in  1  asynchronous active-low reset
- awvalid / awready  in / out  1 / 1  write address handshake
- awaddr  in  32  burst start address
- awlen  in  4  beats minus one; burst type INCR only
- awid  in  8  transaction ID
- wvalid / wready  in / out  1 / 1  write data handshake
- wdata  in  128  beat data
- wstrb  in  16  byte strobes
- wlast  in  1  final beat
- bvalid / bready  out / in  1 / 1  write response handshake
- bid  out  8  echoed awid
- bresp  out  2  always 2'b00 (OKAY)
- uart_txd  out  1  serial output, idle high
- tx_busy  out  1  FIFO non-empty or frame in progress
- test_pass  out  1  sticky pass flag
- test_fail  out  1  sticky fail flag

## Operation
- Write FSM states:
  - W_IDLE: awready=1. On AW handshake, latch awaddr[31:4], awlen and awid, clear the beat counter, and go to W_DATA.
  - W_DATA: wready = !fifo_full. Each W handshake increments the beat counter; the beat address is the latched address + beat counter (4-bit add into [31:4], wrapping within 28 bits). The handshake with wlast goes to W_RESP. wlast is trusted; awlen is used only for the beat count.
  - W_RESP: bvalid=1, bid=latched ID. The bready handshake goes to W_IDLE.
- One transaction outstanding. awready is 0 outside W_IDLE.
- Console extraction, applied when the beat address matches CONSOLE_ADDR. The byte pushed depends on wstrb:
  - 16'h000f: wdata[7:0]
  - 16'h00f0: wdata[39:32]
  - 16'h0f00: wdata[71:64]
  - 16'hf000: wdata[103:96]
  - Any other strobe: no push; the beat still completes.
- Finish detect, applied when the beat address matches FINISH_ADDR and wstrb[7:0]==8'hff:
  - wdata[63:0]==64'h444333222 sets test_pass.
  - wdata[63:0]==64'h2382348720 sets test_fail.
  - Both flags are sticky until reset.
- Other addresses: data discarded, OKAY response.
- UART FSM states: U_IDLE, U_START, U_DATA, U_STOP.
  - U_IDLE with FIFO non-empty: pop and load the shift register, go to U_START.
  - U_START (txd=0) → U_DATA.
  - U_DATA: 8 bits, LSB first.
  - U_STOP (txd=1). At the end of U_STOP, pop again if non-empty and go straight to U_START (no gap); otherwise go to U_IDLE.
  - Each state/bit lasts CLK_DIV cycles, counted by a $clog2(CLK_DIV) counter.
- FIFO push and pop in the same cycle is legal even when full. wready uses the pre-pop full flag.

## Timing
- Reset values:
  - awready=0, wready=0, bvalid=0, bid=0, bresp=0
  - uart_txd=1, tx_busy=0, test_pass=0, test_fail=0
  - Both FSMs in idle; FIFO empty.
- awready rises the first cycle after rst_b deasserts.
- bvalid asserts the cycle after the wlast handshake.
- A push is visible to the UART FSM the cycle after the W handshake. uart_txd falls 2 cycles after the handshake (1 cycle push, 1 cycle pop/load).
- Frame length: exactly 10*CLK_DIV cycles. Back-to-back frames have no idle bit.
- test_pass/test_fail assert the cycle after the matching W handshake.
- Reset asserted mid-burst or mid-frame aborts everything immediately. txd returns to 1 and queued bytes are lost.

## Configuration
- AXI_CONSOLE_FINISH_EN:
  - Defined: finish-word detection as above.
  - Undefined: test_pass and test_fail are tied 0, no comparators are built, and FINISH_ADDR writes behave as ordinary discarded writes.

## Structure
- Package axi_console_pkg holds:
  - Write and UART state enums
  - PASS_WORD (64'h444333222) and FAIL_WORD (64'h2382348720)
  - BRESP_OKAY
- Sub-module console_fifo: 8-bit synchronous FIFO, parameter FIFO_DEPTH.
  - Pointers are $clog2(FIFO_DEPTH)+1 bits wide; the extra bit distinguishes full from empty.
  - Ports: push, din, pop, dout, full, empty.

## Test plan
- Single beat to 32'h01ff_fff0 with wstrb=16'h000f and wdata[7:0]=8'h41, CLK_DIV=4 → bvalid next cycle with bid echoed. uart_txd shows start 0, bits 1,0,0,0,0,0,1,0, stop 1, 40 cycles total.
- 4-beat burst at 32'h01ff_ffd0 (beat 2 hits console) with wstrb=16'hf000 and byte 8'h5a on that beat → exactly one byte 8'h5a transmitted; beats 0, 1 and 3 discarded.
- 20 console writes, FIFO_DEPTH=16, UART slow → wready drops when the FIFO holds 16 entries. All 20 bytes emerge in order, with no gaps between frames.
- FINISH_ADDR write of 64'h444333222 with wstrb[7:0]=8'hff → test_pass=1 next cycle and stays 1. Same test with the macro undefined → test_pass stays 0.
- Console write with wstrb=16'h00ff → no byte transmitted, OKAY response.
- rst_b pulsed low mid-frame with 3 bytes queued → uart_txd=1 immediately, tx_busy=0, no further frames.
